// File: rtl/block_fetch_engine.sv
// Block fetcher for the IDCT stage: reads one BLOCK_DIM x BLOCK_DIM block from SRAM
// at one sample per cycle and writes PACK-sample words into a ping-pong RAM bank.
module block_fetch_engine #(
  parameter int BLOCK_DIM    = 8,
  parameter int PIX_W        = 16,
  parameter int PACK         = 2,
  parameter int SRAM_ADDR_W  = 18,
  parameter int BASE_OFFSET  = 76800,
  parameter int SRAM_LATENCY = 2,
  parameter int RAM_ADDR_W   = 7
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic [5:0]              i_block_col,
  input  logic [5:0]              i_block_row,
  input  logic [9:0]              i_line_stride,
  input  logic                    i_bank_sel,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [SRAM_ADDR_W-1:0]  o_sram_address,
  output logic                    o_sram_we_n,
  input  logic [PIX_W-1:0]        i_sram_read_data,
  output logic [RAM_ADDR_W-1:0]   o_ram_address,
  output logic [PIX_W*PACK-1:0]   o_ram_write_data,
  output logic                    o_ram_we
);

  localparam int NS  = BLOCK_DIM * BLOCK_DIM;
  localparam int NW  = NS / PACK;
  localparam int WW  = PIX_W * PACK;
  localparam int CW  = $clog2(BLOCK_DIM);
  localparam int KW  = $clog2(NS + 1);
  localparam int JW  = $clog2(NW + 1);
  localparam int PKW = $clog2(PACK + 1);
  localparam int DW  = $clog2(SRAM_LATENCY + 1);
  localparam int LW  = SRAM_LATENCY;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]             r_state;
  logic [SRAM_ADDR_W-1:0] r_row_ptr;
  logic [9:0]             r_stride;
  logic                   r_bank;
  logic [CW-1:0]          r_col;
  logic [KW-1:0]          r_issue_cnt;
  logic [DW-1:0]          r_drain_cnt;
  logic [LW-1:0]          r_vpipe;
  logic [WW-1:0]          r_pack;
  logic [PKW-1:0]         r_pack_cnt;
  logic [JW-1:0]          r_word_cnt;

  logic                   w_accept;
  logic                   w_issue;
  logic                   w_capture;
  logic [SRAM_ADDR_W-1:0] w_row_off;
  logic [SRAM_ADDR_W-1:0] w_col_off;
  logic [SRAM_ADDR_W-1:0] w_blk_base;
  logic [WW-1:0]          w_pack_next;
  logic [RAM_ADDR_W-1:0]  w_bank_base;

  assign w_accept  = (r_state == S_IDLE) && i_start;
  assign w_issue   = (r_state == S_ISSUE);
  assign w_capture = r_vpipe[LW-1];

  // The only multiply is the one-off block base at accept time; per-sample addressing is additive.
  assign w_row_off  = SRAM_ADDR_W'(i_block_row) * SRAM_ADDR_W'(BLOCK_DIM) * SRAM_ADDR_W'(i_line_stride);
  assign w_col_off  = SRAM_ADDR_W'(i_block_col) * SRAM_ADDR_W'(BLOCK_DIM);
  assign w_blk_base = SRAM_ADDR_W'(BASE_OFFSET) + w_row_off + w_col_off;

  assign w_pack_next = (r_pack << PIX_W) | WW'(i_sram_read_data);
  assign w_bank_base = r_bank ? RAM_ADDR_W'(NW) : {RAM_ADDR_W{1'b0}};

  assign o_sram_we_n = 1'b1;

  // Control FSM and SRAM address generator.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state        <= S_IDLE;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
      o_sram_address <= SRAM_ADDR_W'(BASE_OFFSET);
      r_row_ptr      <= {SRAM_ADDR_W{1'b0}};
      r_stride       <= 10'd0;
      r_bank         <= 1'b0;
      r_col          <= {CW{1'b0}};
      r_issue_cnt    <= {KW{1'b0}};
      r_drain_cnt    <= {DW{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            r_state     <= S_ISSUE;
            o_busy      <= 1'b1;
            r_row_ptr   <= w_blk_base;
            r_stride    <= i_line_stride;
            r_bank      <= i_bank_sel;
            r_col       <= {CW{1'b0}};
            r_issue_cnt <= {KW{1'b0}};
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ISSUE: begin
          o_sram_address <= r_row_ptr + SRAM_ADDR_W'(r_col);
          if (r_col == CW'(BLOCK_DIM - 1)) begin
            r_col     <= {CW{1'b0}};
            r_row_ptr <= r_row_ptr + SRAM_ADDR_W'(r_stride);
          end else begin
            r_col <= r_col + CW'(1);
          end
          if (r_issue_cnt == KW'(NS - 1)) begin
            r_state     <= S_DRAIN;
            r_drain_cnt <= {DW{1'b0}};
          end else begin
            r_issue_cnt <= r_issue_cnt + KW'(1);
          end
        end
        S_DRAIN: begin
          // Stay long enough for the last sample to land and its word to be written.
          if (r_drain_cnt == DW'(SRAM_LATENCY)) begin
            r_state <= S_IDLE;
            o_busy  <= 1'b0;
            o_done  <= 1'b1;
          end else begin
            r_drain_cnt <= r_drain_cnt + DW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          o_busy  <= 1'b0;
          o_done  <= 1'b0;
        end
      endcase
    end
  end

  // Read-data capture, sample packing and RAM write port.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_vpipe          <= {LW{1'b0}};
      r_pack           <= {WW{1'b0}};
      r_pack_cnt       <= {PKW{1'b0}};
      r_word_cnt       <= {JW{1'b0}};
      o_ram_we         <= 1'b0;
      o_ram_address    <= {RAM_ADDR_W{1'b0}};
      o_ram_write_data <= {WW{1'b0}};
    end else begin
      r_vpipe <= (r_vpipe << 1) | LW'(w_issue);
      if (w_accept) begin
        r_pack_cnt <= {PKW{1'b0}};
        r_word_cnt <= {JW{1'b0}};
        o_ram_we   <= 1'b0;
      end else if (w_capture) begin
        if (r_pack_cnt == PKW'(PACK - 1)) begin
          o_ram_we         <= 1'b1;
          o_ram_write_data <= w_pack_next;
          o_ram_address    <= w_bank_base + RAM_ADDR_W'(r_word_cnt);
          r_word_cnt       <= r_word_cnt + JW'(1);
          r_pack_cnt       <= {PKW{1'b0}};
        end else begin
          o_ram_we   <= 1'b0;
          r_pack     <= w_pack_next;
          r_pack_cnt <= r_pack_cnt + PKW'(1);
        end
      end else begin
        o_ram_we <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_block_fetch_engine.sv
// Self-checking bench for block_fetch_engine: per-cycle reference model built from the
// fetch rules (address formula, write schedule, done timing) plus table and corner sequences.
module tb_block_fetch_engine;
  localparam int BD = 8, PW = 16, PK = 2, AW = 18, BASE = 76800, LAT = 2, RW = 7;
  localparam int NS = BD * BD, NW = NS / PK;
  localparam int PIDX = (LAT >= 2) ? LAT - 2 : 0;

  logic i_clk = 1'b0, i_rst = 1'b1, i_start = 1'b0, i_bank_sel = 1'b0;
  logic [5:0] i_block_col = 6'd0, i_block_row = 6'd0;
  logic [9:0] i_line_stride = 10'd320;
  logic o_busy, o_done, o_sram_we_n, o_ram_we;
  logic [AW-1:0] o_sram_address;
  logic [PW-1:0] i_sram_read_data;
  logic [RW-1:0] o_ram_address;
  logic [PW*PK-1:0] o_ram_write_data;

  always #5 i_clk = ~i_clk;

  block_fetch_engine dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_block_col(i_block_col),
    .i_block_row(i_block_row), .i_line_stride(i_line_stride), .i_bank_sel(i_bank_sel),
    .o_busy(o_busy), .o_done(o_done), .o_sram_address(o_sram_address),
    .o_sram_we_n(o_sram_we_n), .i_sram_read_data(i_sram_read_data),
    .o_ram_address(o_ram_address), .o_ram_write_data(o_ram_write_data), .o_ram_we(o_ram_we));

  // SRAM model: data = address[15:0], valid LAT cycles after the address is driven
  logic [AW-1:0] sram_pipe [0:7];
  initial for (int i = 0; i < 8; i++) sram_pipe[i] = '0;
  always @(posedge i_clk) begin
    sram_pipe[0] <= o_sram_address;
    for (int i = 1; i < 8; i++) sram_pipe[i] <= sram_pipe[i-1];
  end
  assign i_sram_read_data = (LAT == 1) ? o_sram_address[15:0] : sram_pipe[PIDX][15:0];

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model state
  typedef struct { longint t; logic [RW-1:0] a; logic [PW*PK-1:0] d; } wr_t;
  wr_t m_q[$];
  longint cyc = 0, m_e0 = 0, m_free_at = 0, m_done_at = -1;
  bit m_active = 0;
  logic [AW-1:0] m_base = '0, m_hold = AW'(BASE);
  longint m_stride = 0;
  longint done_cycs[$];
  int f_we = 0, f_done = 0;
  logic [AW-1:0] f_first, f_row2, f_last;
  logic [RW-1:0] f_ram0, f_ramN;

  function automatic logic [AW-1:0] ref_addr(input int k);
    longint v;
    v = longint'(m_base) + longint'(k / BD) * m_stride + longint'(k % BD);
    return v[AW-1:0];
  endfunction

  function automatic logic [AW-1:0] exp_addr(input longint c);
    if (!m_active || c <= m_e0) return m_hold;
    else if (c <= m_e0 + NS) return ref_addr(int'(c - m_e0 - 1));
    else return ref_addr(NS - 1);
  endfunction

  // Per-cycle model update at each edge, then compare outputs 1 ns later
  always @(posedge i_clk) begin
    longint v;
    wr_t w;
    logic [AW-1:0] a;
    bit exp_we;
    cyc++;
    if (i_rst) begin
      m_active = 0; m_q.delete(); m_done_at = -1; m_hold = AW'(BASE); m_free_at = 0;
    end else if (i_start && cyc >= m_free_at) begin
      m_hold = exp_addr(cyc);
      m_e0 = cyc; m_active = 1;
      m_free_at = cyc + NS + LAT + 2;
      m_done_at = cyc + NS + LAT + 1;
      v = BASE + longint'(i_block_row) * BD * longint'(i_line_stride) + longint'(i_block_col) * BD;
      m_base = v[AW-1:0];
      m_stride = longint'(i_line_stride);
      for (int j = 0; j < NW; j++) begin
        w.t = cyc + 1 + PK * j + PK - 1 + LAT;
        w.a = RW'(i_bank_sel ? NW + j : j);
        w.d = '0;
        for (int i = 0; i < PK; i++) begin
          a = ref_addr(PK * j + i);
          w.d = {w.d[PW*PK-PW-1:0], a[15:0]};
        end
        m_q.push_back(w);
      end
      f_we = 0; f_done = 0;
    end
    #1;
    chk("sram_we_n", 64'(o_sram_we_n), 64'd1);
    chk("busy", 64'(o_busy), 64'(m_active && cyc >= m_e0 && cyc < m_e0 + NS + LAT + 1));
    chk("done", 64'(o_done), 64'(cyc == m_done_at));
    chk("sram_address", 64'(o_sram_address), 64'(exp_addr(cyc)));
    exp_we = (m_q.size() > 0) && (m_q[0].t == cyc);
    chk("ram_we", 64'(o_ram_we), 64'(exp_we));
    if (exp_we) begin
      chk("ram_address", 64'(o_ram_address), 64'(m_q[0].a));
      chk("ram_write_data", 64'(o_ram_write_data), 64'(m_q[0].d));
      void'(m_q.pop_front());
    end
    if (i_rst) begin
      chk("rst ram_address", 64'(o_ram_address), 64'd0);
      chk("rst ram_write_data", 64'(o_ram_write_data), 64'd0);
    end
    if (o_ram_we === 1'b1) begin
      f_we++;
      if (f_we == 1) f_ram0 = o_ram_address;
      f_ramN = o_ram_address;
    end
    if (o_done === 1'b1) begin f_done++; done_cycs.push_back(cyc); end
    if (m_active && cyc == m_e0 + 1) f_first = o_sram_address;
    if (m_active && cyc == m_e0 + 1 + BD) f_row2 = o_sram_address;
    if (m_active && cyc == m_e0 + NS) f_last = o_sram_address;
  end

  task automatic wait_done(input int budget);
    int n = 0;
    while (o_done !== 1'b1 && n < budget) begin @(posedge i_clk); #2; n++; end
    n_cmp++;
    if (o_done !== 1'b1) begin n_err++; $display("FAIL wait_done timeout after %0d cycles", budget); end
  endtask

  task automatic do_fetch(input logic [5:0] c, input logic [5:0] r, input logic [9:0] s,
                          input logic b, input bit poke);
    @(posedge i_clk); #3;
    i_block_col = c; i_block_row = r; i_line_stride = s; i_bank_sel = b; i_start = 1'b1;
    @(posedge i_clk); #3;
    i_start = 1'b0;
    if (poke) begin
      repeat (10) @(posedge i_clk);
      #3; i_block_col = 6'($urandom); i_block_row = 6'($urandom); i_bank_sel = ~b; i_start = 1'b1;
      @(posedge i_clk); #3; i_start = 1'b0;
    end
    wait_done(200);
    repeat (3) @(posedge i_clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " busy"}, 64'(o_busy), 64'd0);
    chk({tag, " done"}, 64'(o_done), 64'd0);
    chk({tag, " ram_we"}, 64'(o_ram_we), 64'd0);
    chk({tag, " sram_address"}, 64'(o_sram_address), 64'(BASE));
    chk({tag, " sram_we_n"}, 64'(o_sram_we_n), 64'd1);
    chk({tag, " ram_address"}, 64'(o_ram_address), 64'd0);
    chk({tag, " ram_write_data"}, 64'(o_ram_write_data), 64'd0);
  endtask

  typedef struct {
    logic [5:0] col; logic [5:0] row; logic [9:0] stride; logic bank;
    longint first; longint row2; longint last; longint ram0;
  } vec_t;
  vec_t tbl[3];

  initial begin
    int nd, nw;
    tbl[0] = '{6'd0,  6'd0,  10'd320, 1'b0, 76800,  77120,  79047,  0};
    tbl[1] = '{6'd39, 6'd29, 10'd320, 1'b0, 151352, 151672, 153599, 0};
    tbl[2] = '{6'd2,  6'd1,  10'd160, 1'b1, 78096,  78256,  79223,  32};

    repeat (3) @(posedge i_clk);
    #3; i_rst = 1'b0;
    repeat (4) @(posedge i_clk);

    // Reset asserted while idle
    #3; i_rst = 1'b1; #1;
    chk_reset_outputs("idle reset");
    repeat (2) @(posedge i_clk);
    #3; i_rst = 1'b0;

    // Directed block table
    for (int v = 0; v < 3; v++) begin
      do_fetch(tbl[v].col, tbl[v].row, tbl[v].stride, tbl[v].bank, 1'b0);
      chk($sformatf("vec%0d first addr", v), 64'(f_first), 64'(tbl[v].first));
      chk($sformatf("vec%0d row2 addr", v), 64'(f_row2), 64'(tbl[v].row2));
      chk($sformatf("vec%0d last addr", v), 64'(f_last), 64'(tbl[v].last));
      chk($sformatf("vec%0d first ram addr", v), 64'(f_ram0), 64'(tbl[v].ram0));
      chk($sformatf("vec%0d last ram addr", v), 64'(f_ramN), 64'(tbl[v].ram0 + NW - 1));
      chk($sformatf("vec%0d writes", v), 64'(f_we), 64'(NW));
      chk($sformatf("vec%0d dones", v), 64'(f_done), 64'd1);
    end

    // Random blocks with an ignored start pulse mid-fetch
    for (int v = 0; v < 6; v++) begin
      do_fetch(6'($urandom_range(0, 39)), 6'($urandom_range(0, 63)),
               ($urandom_range(0, 1) == 0) ? 10'd160 : 10'($urandom), 1'($urandom), 1'b1);
      chk($sformatf("rand%0d writes", v), 64'(f_we), 64'(NW));
      chk($sformatf("rand%0d dones", v), 64'(f_done), 64'd1);
    end

    // start held high: back-to-back fetches, inputs churned mid-fetch
    done_cycs.delete();
    @(posedge i_clk); #3; i_start = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge i_clk); #3;
      if (i % 9 == 4) begin
        i_block_col = 6'($urandom); i_block_row = 6'($urandom_range(0, 29));
        i_line_stride = ($urandom_range(0, 1) == 0) ? 10'd160 : 10'd320; i_bank_sel = 1'($urandom);
      end
    end
    i_start = 1'b0;
    wait_done(200);
    repeat (3) @(posedge i_clk);
    chk("b2b done count >= 3", 64'(done_cycs.size() >= 3), 64'd1);
    for (int i = 1; i < done_cycs.size(); i++)
      chk($sformatf("b2b done spacing %0d", i), 64'(done_cycs[i] - done_cycs[i-1]), 64'(NS + LAT + 2));

    // Reset 20 cycles after accept aborts the fetch
    @(posedge i_clk); #3;
    i_block_col = 6'd5; i_block_row = 6'd3; i_line_stride = 10'd320; i_bank_sel = 1'b0; i_start = 1'b1;
    @(posedge i_clk); #3; i_start = 1'b0;
    repeat (20) @(posedge i_clk);
    #3; i_rst = 1'b1; #1;
    chk_reset_outputs("abort reset");
    repeat (2) @(posedge i_clk);
    #3; i_rst = 1'b0;
    nd = 0; nw = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge i_clk); #2;
      if (o_done === 1'b1) nd++;
      if (o_ram_we === 1'b1) nw++;
    end
    chk("abort no done", 64'(nd), 64'd0);
    chk("abort no writes", 64'(nw), 64'd0);
    do_fetch(tbl[0].col, tbl[0].row, tbl[0].stride, tbl[0].bank, 1'b0);
    chk("post-abort first addr", 64'(f_first), 64'(tbl[0].first));
    chk("post-abort last addr", 64'(f_last), 64'(tbl[0].last));
    chk("post-abort writes", 64'(f_we), 64'(NW));
    chk("post-abort dones", 64'(f_done), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
